// File: rtl/sync_frame_tx_pkg.sv
// Shared types and defaults for the sync-word frame transmitter.
// Used by the transmitter RTL and by transmitter/detector benches.
package sync_frame_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int                    SYNC_W_DEF   = 5;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 5'b10010;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_frame_tx_bit_counter.sv
// frame_bit_counter: loadable down-counter with a zero flag.
// Ports: clk, rstn, i_load/i_load_val (reload), i_dec, o_cnt, o_zero.
module frame_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at zero so a stray decrement never wraps within a state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, payload (MSB first), idle gap.
// Ports: clk, rstn, load/data_in (request), ready, w, tx_active, done.
module sync_frame_tx
    import sync_frame_tx_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter int                GAP_LEN  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              w,
    output logic              tx_active,
    output logic              done
);

    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_LEN)) + 1;

    // Counter holds "cycles left in this state minus one".
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

    state_t            r_state;
    logic              r_w;
    logic              r_done;
    logic [SYNC_W-1:0] r_sync;
    logic [DATA_W-1:0] r_pay;

    state_t            w_state_nx;
    logic              w_w_nx;
    logic              w_done_nx;
    logic              w_accept;
    logic              w_sync_shift;
    logic              w_pay_shift;
    logic              w_cnt_ld;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_dec;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_cnt_zero;

    assign w_accept = load && (r_state == IDLE);

    frame_bit_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .i_load    (w_cnt_ld),
        .i_load_val(w_cnt_val),
        .i_dec     (w_cnt_dec),
        .o_cnt     (w_cnt),
        .o_zero    (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // The line bit and done are registered together with the state,
    // so w/done describe the state the FSM is in during that cycle.
    always_comb begin
        w_state_nx   = r_state;
        w_w_nx       = 1'b0;
        w_done_nx    = 1'b0;
        w_sync_shift = 1'b0;
        w_pay_shift  = 1'b0;
        w_cnt_ld     = 1'b0;
        w_cnt_val    = '0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_nx = SYNC;
                    w_w_nx     = SYNC_PAT[SYNC_W-1];
                    w_cnt_ld   = 1'b1;
                    w_cnt_val  = SYNC_LAST;
                end
            end
            SYNC: begin
                if (w_cnt_zero) begin
                    w_state_nx  = DATA;
                    w_w_nx      = r_pay[DATA_W-1];
                    w_pay_shift = 1'b1;
                    w_cnt_ld    = 1'b1;
                    w_cnt_val   = DATA_LAST;
                    w_done_nx   = (DATA_W == 1);
                end else begin
                    w_w_nx       = r_sync[SYNC_W-1];
                    w_sync_shift = 1'b1;
                    w_cnt_dec    = 1'b1;
                end
            end
            DATA: begin
                if (w_cnt_zero) begin
                    if (GAP_LEN == 0) begin
                        w_state_nx = IDLE;
                    end else begin
                        w_state_nx = GAP;
                        w_cnt_ld   = 1'b1;
                        w_cnt_val  = GAP_LAST;
                    end
                end else begin
                    w_w_nx      = r_pay[DATA_W-1];
                    w_pay_shift = 1'b1;
                    w_cnt_dec   = 1'b1;
                    // Loading the final payload bit onto the line.
                    w_done_nx   = (w_cnt == CNT_W'(1));
                end
            end
            GAP: begin
                if (w_cnt_zero) begin
                    w_state_nx = IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // r_sync holds the sync bits still to be sent, MSB aligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
            r_pay  <= '0;
        end else begin
            if (w_accept) begin
                r_sync <= SYNC_PAT << 1;
                r_pay  <= data_in;
            end else begin
                if (w_sync_shift) begin
                    r_sync <= r_sync << 1;
                end
                if (w_pay_shift) begin
                    r_pay <= r_pay << 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w    <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_w    <= w_w_nx;
            r_done <= w_done_nx;
        end
    end

    assign ready     = (r_state == IDLE);
    assign tx_active = (r_state == SYNC) || (r_state == DATA);
    assign w         = r_w;
    assign done      = r_done;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: default build plus a
// SYNC_W=7 / GAP_LEN=3 build sharing clock and reset.
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load;
    logic [7:0] din;
    logic       ready;
    logic       w;
    logic       tx_active;
    logic       done;

    logic       load7;
    logic [7:0] din7;
    logic       ready7;
    logic       w7;
    logic       tx_active7;
    logic       done7;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sync_frame_tx u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .data_in  (din),
        .ready    (ready),
        .w        (w),
        .tx_active(tx_active),
        .done     (done)
    );

    sync_frame_tx #(
        .DATA_W  (8),
        .SYNC_W  (7),
        .SYNC_PAT(7'b1011000),
        .GAP_LEN (3)
    ) u_p7 (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load7),
        .data_in  (din7),
        .ready    (ready7),
        .w        (w7),
        .tx_active(tx_active7),
        .done     (done7)
    );

    task automatic chk(input string tag, input int cyc,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Request a frame on the default instance; returns at cycle 1.
    task automatic start(input logic [7:0] d);
        load = 1'b1;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    // Checks cycles 1..15 of a default frame accepted in cycle 0.
    task automatic frame5(input string tag, input logic [14:0] ew,
                          input bit hold, input logic [7:0] nxt,
                          input bit noise);
        for (int c = 1; c <= 15; c++) begin
            if (noise) begin
                load = (c == 5);
                din  = (c == 5) ? 8'h3C : 8'($urandom);
            end else if (hold) begin
                load = 1'b1;
                din  = nxt;
            end else begin
                load = 1'b0;
                din  = 8'($urandom);
            end
            @(negedge clk);
            chk({tag, ".w"}, c, 32'(w), 32'(ew[15-c]));
            chk({tag, ".done"}, c, 32'(done), 32'(c == 13));
            chk({tag, ".ready"}, c, 32'(ready), 32'(c == 15));
            chk({tag, ".act"}, c, 32'(tx_active), 32'(c <= 13));
            @(posedge clk);
            #1;
        end
    endtask

    // Same for the SYNC_W=7, GAP_LEN=3 instance (19-cycle period).
    task automatic frame7(input string tag, input logic [18:0] ew,
                          input bit hold, input logic [7:0] nxt);
        for (int c = 1; c <= 19; c++) begin
            load7 = hold;
            din7  = hold ? nxt : 8'($urandom);
            @(negedge clk);
            chk({tag, ".w"}, c, 32'(w7), 32'(ew[19-c]));
            chk({tag, ".done"}, c, 32'(done7), 32'(c == 15));
            chk({tag, ".ready"}, c, 32'(ready7), 32'(c == 19));
            chk({tag, ".act"}, c, 32'(tx_active7), 32'(c <= 15));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [14:0] ea5;
        ea5   = {5'b10010, 8'hA5, 2'b00};
        rstn  = 1'b0;
        load  = 1'b0;
        din   = 8'h00;
        load7 = 1'b0;
        din7  = 8'h00;

        #2;
        chk("rst.w", 0, 32'(w), 32'd0);
        chk("rst.ready", 0, 32'(ready), 32'd1);
        chk("rst.act", 0, 32'(tx_active), 32'd0);
        chk("rst.done", 0, 32'(done), 32'd0);
        chk("rst.ready7", 0, 32'(ready7), 32'd1);

        // Load coincident with the first edge after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        load = 1'b1;
        din  = 8'hA5;
        @(posedge clk);
        #1;
        frame5("a5", 15'b100101010010100, 1'b0, 8'h00, 1'b0);

        // Back-to-back frames with load held high.
        start(8'hFF);
        frame5("ff", {5'b10010, 8'hFF, 2'b00}, 1'b1, 8'h00, 1'b0);
        frame5("00", {5'b10010, 8'h00, 2'b00}, 1'b0, 8'h00, 1'b0);

        // Mid-frame request and noisy data_in must not disturb the frame.
        start(8'hA5);
        frame5("noise", ea5, 1'b0, 8'h00, 1'b1);
        for (int c = 16; c <= 19; c++) begin
            load = 1'b0;
            @(negedge clk);
            chk("idle.w", c, 32'(w), 32'd0);
            chk("idle.act", c, 32'(tx_active), 32'd0);
            @(posedge clk);
            #1;
        end

        // Reset in cycle 8 aborts the frame.
        start(8'hA5);
        load = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("pre.w", c, 32'(w), 32'(ea5[15-c]));
            @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        #1;
        chk("abort.w", 8, 32'(w), 32'd0);
        chk("abort.ready", 8, 32'(ready), 32'd1);
        chk("abort.act", 8, 32'(tx_active), 32'd0);
        chk("abort.done", 8, 32'(done), 32'd0);
        for (int c = 9; c <= 15; c++) begin
            @(posedge clk);
            #1;
            chk("abort.done", c, 32'(done), 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        load = 1'b1;
        din  = 8'h81;
        @(posedge clk);
        #1;
        frame5("81", {5'b10010, 8'h81, 2'b00}, 1'b0, 8'h00, 1'b0);

        // Payload containing the sync pattern goes out verbatim.
        start(8'h48);
        frame5("48", {5'b10010, 8'h48, 2'b00}, 1'b0, 8'h00, 1'b0);

        // Wider sync, longer gap, 19-cycle period with load held.
        load7 = 1'b1;
        din7  = 8'hC3;
        @(posedge clk);
        #1;
        frame7("p7c3", {7'b1011000, 8'hC3, 4'b0000}, 1'b1, 8'h5A);
        frame7("p7a5", {7'b1011000, 8'h5A, 4'b0000}, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
